// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the decode-stage register file with forwarding and
// pending-load scoreboard (regfile_fwd_scoreboard).
//   RF_DW / RF_AW : default data and address widths
//   NREG          : default register count (2**RF_AW)
//   fwd_src_e     : which source a read port selected this cycle
// -----------------------------------------------------------------------------
package rf_pkg;

  localparam int RF_DW = 32;
  localparam int RF_AW = 5;
  localparam int NREG  = 2 ** RF_AW;

  // Read-port source selection, listed from highest to lowest priority.
  typedef enum logic [2:0] {
    ZERO = 3'd0,
    EXE  = 3'd1,
    MEM  = 3'd2,
    WB   = 3'd3,
    LD   = 3'd4,
    ARR  = 3'd5
  } fwd_src_e;

  // True when a (valid, destination) pair targets the register being read.
  function automatic logic fwd_hit(input logic valid, input logic [RF_AW-1:0] dst,
                                   input logic [RF_AW-1:0] addr);
    return valid && (dst == addr);
  endfunction

endpackage

// File: rtl/regfile_fwd_scoreboard_if.sv
// -----------------------------------------------------------------------------
// regfile_fwd_scoreboard_if
// Bundles every non-clock/reset signal of the register file.
//   master : decode / pipeline side (drives addresses, forwarding, writes)
//   slave  : the register file (returns read data, stalls, pending state)
// Signals:
//   rd_addr/rd_data/rd_stall     NREAD packed read ports, port p at [p*W +: W]
//   exe_fwd_* / mem_fwd_*        forwarding candidates from EXE and MEM
//   wb_*                         ALU writeback write port
//   ld_issue/ld_rd               load issue, marks destination pending
//   ld_we/ld_addr/ld_data        load return write port, clears pending
//   flush                        clears the whole scoreboard
//   pending                      scoreboard state, bit r = reg r awaits load
// -----------------------------------------------------------------------------
interface regfile_fwd_scoreboard_if
  import rf_pkg::*;
#(
  parameter int DW    = RF_DW,
  parameter int AW    = RF_AW,
  parameter int NREAD = 2
);

  logic [NREAD*AW-1:0] rd_addr;
  logic [NREAD*DW-1:0] rd_data;
  logic [NREAD-1:0]    rd_stall;

  logic                exe_fwd_valid;
  logic [AW-1:0]       exe_fwd_rd;
  logic [DW-1:0]       exe_fwd_data;

  logic                mem_fwd_valid;
  logic [AW-1:0]       mem_fwd_rd;
  logic [DW-1:0]       mem_fwd_data;

  logic                wb_we;
  logic [AW-1:0]       wb_addr;
  logic [DW-1:0]       wb_data;

  logic                ld_issue;
  logic [AW-1:0]       ld_rd;
  logic                ld_we;
  logic [AW-1:0]       ld_addr;
  logic [DW-1:0]       ld_data;

  logic                flush;
  logic [2**AW-1:0]    pending;

  modport master (
    output rd_addr,
    input  rd_data, rd_stall,
    output exe_fwd_valid, exe_fwd_rd, exe_fwd_data,
    output mem_fwd_valid, mem_fwd_rd, mem_fwd_data,
    output wb_we, wb_addr, wb_data,
    output ld_issue, ld_rd, ld_we, ld_addr, ld_data,
    output flush,
    input  pending
  );

  modport slave (
    input  rd_addr,
    output rd_data, rd_stall,
    input  exe_fwd_valid, exe_fwd_rd, exe_fwd_data,
    input  mem_fwd_valid, mem_fwd_rd, mem_fwd_data,
    input  wb_we, wb_addr, wb_data,
    input  ld_issue, ld_rd, ld_we, ld_addr, ld_data,
    input  flush,
    output pending
  );

endinterface

// File: rtl/rf_read_port.sv
// -----------------------------------------------------------------------------
// rf_read_port
// One combinational read port: priority mux over the zero register, the EXE
// and MEM forwarding paths, same-cycle write-through of the WB and LD write
// ports, and finally the stored array value. Also produces the load-use stall.
// Ports:
//   addr       in   register being read
//   arr_data   in   array[addr] supplied by the top
//   pend       in   scoreboard bit for addr
//   exe_*/mem_*     forwarding candidates
//   wb_*/ld_*       write ports seen this cycle (bypass)
//   data       out  selected operand
//   stall      out  operand is a pending load that nothing can supply yet
// -----------------------------------------------------------------------------
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DW       = RF_DW,
  parameter int AW       = RF_AW,
  parameter int ZERO_REG = 1
) (
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] arr_data,
  input  logic          pend,
  input  logic          exe_valid,
  input  logic [AW-1:0] exe_rd,
  input  logic [DW-1:0] exe_data,
  input  logic          mem_valid,
  input  logic [AW-1:0] mem_rd,
  input  logic [DW-1:0] mem_data,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic [DW-1:0] data,
  output logic          stall
);

  fwd_src_e src;

  // First match wins; the order encodes pipeline age (youngest result first).
  always_comb begin
    src = ARR;
    if ((ZERO_REG != 0) && (addr == '0))       src = ZERO;
    else if (exe_valid && (exe_rd == addr))    src = EXE;
    else if (mem_valid && (mem_rd == addr))    src = MEM;
    else if (wb_we && (wb_addr == addr))       src = WB;
    else if (ld_we && (ld_addr == addr))       src = LD;
  end

  always_comb begin
    data = arr_data;
    case (src)
      ZERO:    data = '0;
      EXE:     data = exe_data;
      MEM:     data = mem_data;
      WB:      data = wb_data;
      LD:      data = ld_data;
      default: data = arr_data;
    endcase
  end

  // Only an operand that comes from the array can be stale; any bypass hit
  // (including the returning load itself) supplies a valid value.
  assign stall = pend && (src == ARR);

endmodule

// File: rtl/regfile_fwd_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_fwd_scoreboard
// Decode-stage register file with NREAD combinational read ports, two
// posedge write ports (ALU writeback and load return), generic EXE/MEM
// forwarding with write-through bypass, and a pending-load scoreboard that
// flags load-use hazards per read port.
// Ports:
//   clk          in  clock, all state updates on posedge
//   rf_reset_n   in  asynchronous active-low reset (array and scoreboard)
//   bus          slave modport of regfile_fwd_scoreboard_if
// Parameters:
//   DW, AW, NREAD  data width, address width, number of read ports
//   ZERO_REG       1: register 0 reads zero, ignores writes and load issue
// -----------------------------------------------------------------------------
module regfile_fwd_scoreboard
  import rf_pkg::*;
#(
  parameter int DW       = RF_DW,
  parameter int AW       = RF_AW,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rf_reset_n,
  regfile_fwd_scoreboard_if.slave  bus
);

  localparam int NREGS = 2 ** AW;

  logic [DW-1:0]    mem [NREGS];
  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_d;

  logic             wb_ok;
  logic             ld_ok;
  logic             issue_ok;

  logic [DW-1:0]    port_data  [NREAD];
  logic             port_stall [NREAD];

  // Register 0 filtering for the two write ports and the load issue.
  assign wb_ok    = bus.wb_we    && !((ZERO_REG != 0) && (bus.wb_addr == '0));
  assign ld_ok    = bus.ld_we    && !((ZERO_REG != 0) && (bus.ld_addr == '0));
  assign issue_ok = bus.ld_issue && !((ZERO_REG != 0) && (bus.ld_rd   == '0));

  // Array write: LD first, WB second, so WB wins a same-address collision.
  always_ff @(posedge clk or negedge rf_reset_n) begin
    if (!rf_reset_n) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else begin
      if (ld_ok) mem[bus.ld_addr] <= bus.ld_data;
      if (wb_ok) mem[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Scoreboard next state: flush dominates; a new issue beats a return to
  // the same register, so the clear is applied before the set.
  always_comb begin
    pend_d = pend_q;
    if (bus.flush) begin
      pend_d = '0;
    end else begin
      if (bus.ld_we) pend_d[bus.ld_addr] = 1'b0;
      if (issue_ok)  pend_d[bus.ld_rd]   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rf_reset_n) begin
    if (!rf_reset_n) pend_q <= '0;
    else             pend_q <= pend_d;
  end

  assign bus.pending = pend_q;

  for (genvar p = 0; p < NREAD; p++) begin : g_port
    logic [AW-1:0] addr;
    assign addr = bus.rd_addr[p*AW +: AW];

    rf_read_port #(
      .DW       (DW),
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
    ) u_port (
      .addr      (addr),
      .arr_data  (mem[addr]),
      .pend      (pend_q[addr]),
      .exe_valid (bus.exe_fwd_valid),
      .exe_rd    (bus.exe_fwd_rd),
      .exe_data  (bus.exe_fwd_data),
      .mem_valid (bus.mem_fwd_valid),
      .mem_rd    (bus.mem_fwd_rd),
      .mem_data  (bus.mem_fwd_data),
      .wb_we     (bus.wb_we),
      .wb_addr   (bus.wb_addr),
      .wb_data   (bus.wb_data),
      .ld_we     (bus.ld_we),
      .ld_addr   (bus.ld_addr),
      .ld_data   (bus.ld_data),
      .data      (port_data[p]),
      .stall     (port_stall[p])
    );
  end

  always_comb begin
    bus.rd_data  = '0;
    bus.rd_stall = '0;
    for (int p = 0; p < NREAD; p++) begin
      bus.rd_data[p*DW +: DW] = port_data[p];
      bus.rd_stall[p]         = port_stall[p];
    end
  end

endmodule

// File: tb/tb_regfile_fwd_scoreboard.sv
module tb_regfile_fwd_scoreboard;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NREAD = 3;
  localparam int NREG  = 32;

  logic clk = 1'b0;
  logic rf_reset_n;

  always #5 clk = ~clk;

  regfile_fwd_scoreboard_if #(.DW(DW), .AW(AW), .NREAD(NREAD)) bus ();

  regfile_fwd_scoreboard #(
    .DW(DW), .AW(AW), .NREAD(NREAD), .ZERO_REG(1)
  ) dut (
    .clk        (clk),
    .rf_reset_n (rf_reset_n),
    .bus        (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain register array and pending bit vector.
  logic [DW-1:0]   ref_mem [NREG];
  logic [NREG-1:0] ref_pend;

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) ref_mem[i] = '0;
    ref_pend = '0;
  endtask

  // Architectural value of register a as seen by a reader this cycle.
  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (bus.exe_fwd_valid && bus.exe_fwd_rd == a) return bus.exe_fwd_data;
    if (bus.mem_fwd_valid && bus.mem_fwd_rd == a) return bus.mem_fwd_data;
    if (bus.wb_we && bus.wb_addr == a) return bus.wb_data;
    if (bus.ld_we && bus.ld_addr == a) return bus.ld_data;
    return ref_mem[a];
  endfunction

  function automatic logic exp_stall(input logic [AW-1:0] a);
    logic supplied;
    supplied = (a == 0)
            || (bus.exe_fwd_valid && bus.exe_fwd_rd == a)
            || (bus.mem_fwd_valid && bus.mem_fwd_rd == a)
            || (bus.wb_we && bus.wb_addr == a)
            || (bus.ld_we && bus.ld_addr == a);
    return ref_pend[a] && !supplied;
  endfunction

  // Apply the clock-edge effects of the current inputs to the model.
  task automatic model_edge();
    if (rf_reset_n) begin
      if (bus.ld_we && bus.ld_addr != 0) ref_mem[bus.ld_addr] = bus.ld_data;
      if (bus.wb_we && bus.wb_addr != 0) ref_mem[bus.wb_addr] = bus.wb_data;
      if (bus.flush) ref_pend = '0;
      else begin
        if (bus.ld_we) ref_pend[bus.ld_addr] = 1'b0;
        if (bus.ld_issue && bus.ld_rd != 0) ref_pend[bus.ld_rd] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rd_addr       = '0;
    bus.exe_fwd_valid = 1'b0; bus.exe_fwd_rd = '0; bus.exe_fwd_data = '0;
    bus.mem_fwd_valid = 1'b0; bus.mem_fwd_rd = '0; bus.mem_fwd_data = '0;
    bus.wb_we = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.ld_issue = 1'b0; bus.ld_rd = '0;
    bus.ld_we = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
    bus.flush = 1'b0;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    bus.rd_addr[p*AW +: AW] = a;
  endtask

  function automatic logic [DW-1:0] port_data(input int p);
    return bus.rd_data[p*DW +: DW];
  endfunction

  task automatic test_reset();
    rf_reset_n = 1'b0;
    idle();
    set_rd(0, 5);
    #2;
    n_tests++;
    if (bus.pending !== 32'h0) begin
      n_fail++; $display("FAIL reset_pending_init: got %h expected %h", bus.pending, 32'h0);
    end
    n_tests++;
    if (port_data(0) !== 32'h0 || bus.rd_stall !== 3'b000) begin
      n_fail++; $display("FAIL reset_read_init: got %h/%b expected 0/000", port_data(0), bus.rd_stall);
    end
    @(negedge clk);
    rf_reset_n = 1'b1;
    model_clear();
    bus.wb_we = 1'b1; bus.wb_addr = 5; bus.wb_data = 32'hDEAD;
    bus.ld_issue = 1'b1; bus.ld_rd = 6;
    tick();
    idle();
    set_rd(0, 5);
    #1;
    n_tests++;
    if (port_data(0) !== 32'hDEAD || bus.pending !== 32'h40) begin
      n_fail++; $display("FAIL reset_prewrite: got %h/%h expected %h/%h", port_data(0), bus.pending, 32'hDEAD, 32'h40);
    end
    #2;
    rf_reset_n = 1'b0;
    #1;
    n_tests++;
    if (port_data(0) !== 32'h0 || bus.pending !== 32'h0) begin
      n_fail++; $display("FAIL reset_async: got %h/%h expected 0/0", port_data(0), bus.pending);
    end
    model_clear();
    // Writes and issues presented across an edge while reset is held.
    bus.wb_we = 1'b1; bus.wb_addr = 5; bus.wb_data = 32'h1234;
    bus.ld_issue = 1'b1; bus.ld_rd = 6;
    tick();
    idle();
    set_rd(0, 5);
    @(negedge clk);
    rf_reset_n = 1'b1;
    #1;
    n_tests++;
    if (port_data(0) !== 32'h0 || bus.pending !== 32'h0) begin
      n_fail++; $display("FAIL reset_write_ignored: got %h/%h expected 0/0", port_data(0), bus.pending);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_priority();
    idle();
    set_rd(0, 3); set_rd(1, 3);
    bus.exe_fwd_valid = 1'b1; bus.exe_fwd_rd = 3; bus.exe_fwd_data = 32'h11;
    bus.mem_fwd_valid = 1'b1; bus.mem_fwd_rd = 3; bus.mem_fwd_data = 32'h22;
    bus.wb_we = 1'b1; bus.wb_addr = 3; bus.wb_data = 32'h33;
    bus.ld_we = 1'b1; bus.ld_addr = 3; bus.ld_data = 32'h44;
    #1;
    n_tests++;
    if (port_data(0) !== 32'h11 || port_data(1) !== 32'h11) begin
      n_fail++; $display("FAIL prio_exe: got %h/%h expected %h", port_data(0), port_data(1), 32'h11);
    end
    bus.exe_fwd_valid = 1'b0;
    #1;
    n_tests++;
    if (port_data(0) !== 32'h22) begin
      n_fail++; $display("FAIL prio_mem: got %h expected %h", port_data(0), 32'h22);
    end
    bus.mem_fwd_valid = 1'b0;
    #1;
    n_tests++;
    if (port_data(0) !== 32'h33) begin
      n_fail++; $display("FAIL prio_wb: got %h expected %h", port_data(0), 32'h33);
    end
    bus.wb_we = 1'b0;
    #1;
    n_tests++;
    if (port_data(0) !== 32'h44) begin
      n_fail++; $display("FAIL prio_ld: got %h expected %h", port_data(0), 32'h44);
    end
    idle();
    tick();
  endtask

  task automatic test_load_use();
    idle();
    bus.ld_issue = 1'b1; bus.ld_rd = 7;
    tick();
    idle();
    set_rd(0, 7); set_rd(1, 7);
    #1;
    n_tests++;
    if (bus.rd_stall !== 3'b011) begin
      n_fail++; $display("FAIL loaduse_stall: got %b expected %b", bus.rd_stall, 3'b011);
    end
    bus.ld_we = 1'b1; bus.ld_addr = 7; bus.ld_data = 32'hCAFE;
    #1;
    n_tests++;
    if (bus.rd_stall !== 3'b000 || port_data(0) !== 32'hCAFE) begin
      n_fail++; $display("FAIL loaduse_bypass: got %b/%h expected 000/%h", bus.rd_stall, port_data(0), 32'hCAFE);
    end
    tick();
    idle();
    set_rd(0, 7);
    #1;
    n_tests++;
    if (bus.pending[7] !== 1'b0 || port_data(0) !== 32'hCAFE) begin
      n_fail++; $display("FAIL loaduse_after: got %b/%h expected 0/%h", bus.pending[7], port_data(0), 32'hCAFE);
    end
  endtask

  task automatic test_collision();
    idle();
    bus.ld_issue = 1'b1; bus.ld_rd = 9;
    tick();
    idle();
    set_rd(0, 9);
    bus.wb_we = 1'b1; bus.wb_addr = 9; bus.wb_data = 32'h1;
    bus.ld_we = 1'b1; bus.ld_addr = 9; bus.ld_data = 32'h2;
    tick();
    idle();
    set_rd(0, 9);
    #1;
    n_tests++;
    if (port_data(0) !== 32'h1 || bus.pending[9] !== 1'b0) begin
      n_fail++; $display("FAIL collision: got %h/%b expected %h/0", port_data(0), bus.pending[9], 32'h1);
    end
  endtask

  task automatic test_flush_race();
    idle();
    bus.flush = 1'b1; bus.ld_issue = 1'b1; bus.ld_rd = 4;
    tick();
    idle();
    #1;
    n_tests++;
    if (bus.pending !== 32'h0) begin
      n_fail++; $display("FAIL flush_issue: got %h expected %h", bus.pending, 32'h0);
    end
    bus.ld_issue = 1'b1; bus.ld_rd = 4;
    bus.ld_we = 1'b1; bus.ld_addr = 4; bus.ld_data = 32'h55;
    tick();
    idle();
    set_rd(0, 4);
    #1;
    n_tests++;
    if (bus.pending !== 32'h10 || bus.rd_stall[0] !== 1'b1) begin
      n_fail++; $display("FAIL issue_return_race: got %h/%b expected %h/1", bus.pending, bus.rd_stall[0], 32'h10);
    end
    bus.ld_we = 1'b1; bus.ld_addr = 4; bus.ld_data = 32'h56;
    tick();
    idle();
  endtask

  task automatic test_zero_reg();
    idle();
    for (int p = 0; p < NREAD; p++) set_rd(p, 0);
    bus.wb_we = 1'b1; bus.wb_addr = 0; bus.wb_data = 32'hFFFF;
    bus.ld_issue = 1'b1; bus.ld_rd = 0;
    bus.exe_fwd_valid = 1'b1; bus.exe_fwd_rd = 0; bus.exe_fwd_data = 32'h123;
    #1;
    n_tests++;
    if (bus.rd_data !== '0 || bus.rd_stall !== 3'b000) begin
      n_fail++; $display("FAIL zero_same_cycle: got %h/%b expected 0/000", bus.rd_data, bus.rd_stall);
    end
    tick();
    idle();
    for (int p = 0; p < NREAD; p++) set_rd(p, 0);
    #1;
    n_tests++;
    if (bus.rd_data !== '0 || bus.rd_stall !== 3'b000 || bus.pending[0] !== 1'b0) begin
      n_fail++; $display("FAIL zero_after: got %h/%b/%b expected 0/000/0", bus.rd_data, bus.rd_stall, bus.pending[0]);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < NREAD; p++) set_rd(p, AW'($urandom_range(0, 7)));
      bus.exe_fwd_valid = ($urandom_range(0, 3) == 0);
      bus.exe_fwd_rd    = AW'($urandom_range(0, 7));
      bus.exe_fwd_data  = $urandom;
      bus.mem_fwd_valid = ($urandom_range(0, 3) == 0);
      bus.mem_fwd_rd    = AW'($urandom_range(0, 7));
      bus.mem_fwd_data  = $urandom;
      bus.wb_we         = ($urandom_range(0, 2) == 0);
      bus.wb_addr       = AW'($urandom_range(0, 7));
      bus.wb_data       = $urandom;
      bus.ld_issue      = ($urandom_range(0, 2) == 0);
      bus.ld_rd         = AW'($urandom_range(0, 7));
      bus.ld_we         = ($urandom_range(0, 2) == 0);
      bus.ld_addr       = AW'($urandom_range(0, 7));
      bus.ld_data       = $urandom;
      bus.flush         = ($urandom_range(0, 15) == 0);
      #1;
      for (int p = 0; p < NREAD; p++) begin
        a = bus.rd_addr[p*AW +: AW];
        n_tests++;
        if (port_data(p) !== exp_data(a) || bus.rd_stall[p] !== exp_stall(a)) begin
          n_fail++;
          $display("FAIL rand_read c=%0d p=%0d r=%0d: got %h/%b expected %h/%b",
                   c, p, a, port_data(p), bus.rd_stall[p], exp_data(a), exp_stall(a));
        end
      end
      n_tests++;
      if (bus.pending !== ref_pend) begin
        n_fail++; $display("FAIL rand_pending c=%0d: got %h expected %h", c, bus.pending, ref_pend);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_load_use();
    test_collision();
    test_flush_race();
    test_zero_reg();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
